// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory access port between requester A (CPU
// load/store unit) and requester B (debug/program loader). A has fixed priority;
// a starvation guard forces B ahead after MAX_WAIT consecutive denied cycles.
// Addresses are checked against the data-memory window and translated to
// window-relative byte addresses. Responses are registered with 1-cycle latency.
// Optional feature: define DMEM_ARB_PERF_EN to add conflict_cnt_o, a wrapping
// count of cycles where both requesters ask at once.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADR = 32'h0000_4000,
  parameter int unsigned DEPTH    = 16384,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [31:0] a_adr_i,
  input  logic [31:0] a_wd_i,
  input  logic [1:0]  a_sel_i,
  output logic        a_gnt_o,
  output logic        a_rvalid_o,
  output logic [31:0] a_rdata_o,
  output logic        a_err_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [31:0] b_adr_i,
  input  logic [31:0] b_wd_i,
  input  logic [1:0]  b_sel_i,
  output logic        b_gnt_o,
  output logic        b_rvalid_o,
  output logic [31:0] b_rdata_o,
  output logic        b_err_o,
  output logic        mem_we_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_wd_o,
  output logic [1:0]  mem_sel_o,
  input  logic [31:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  // One bit wider than the address so a window ending at 4 GB does not wrap.
  localparam logic [32:0] END_ADR    = {1'b0, BASE_ADR} + (33'(DEPTH) << 2);
  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  b_wait;
  logic        b_starved;
  logic        granted;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_wd;
  logic [1:0]  req_sel;
  logic        in_window;
  logic        req_err;
  logic [31:0] resp_rdata;

  assign b_starved = (b_wait == MAX_WAIT_C);

  // Grant decision: A wins unless B has waited MAX_WAIT cycles; nothing during reset.
  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    if (!reset_i) begin
      if (b_req_i && (!a_req_i || b_starved)) begin
        b_gnt_o = 1'b1;
      end else if (a_req_i) begin
        a_gnt_o = 1'b1;
      end
    end
  end

  // Select the granted requester's fields; A's fields are a don't-care default.
  always_comb begin
    req_we  = a_we_i;
    req_adr = a_adr_i;
    req_wd  = a_wd_i;
    req_sel = a_sel_i;
    if (b_gnt_o) begin
      req_we  = b_we_i;
      req_adr = b_adr_i;
      req_wd  = b_wd_i;
      req_sel = b_sel_i;
    end
  end

  assign granted   = a_gnt_o | b_gnt_o;
  assign in_window = ({1'b0, req_adr} >= {1'b0, BASE_ADR}) && ({1'b0, req_adr} < END_ADR);

  // Error check: out of window, reserved size, or misaligned half/word access.
  always_comb begin
    req_err = !in_window;
    unique case (size_e'(req_sel))
      SZ_RSVD: req_err = 1'b1;
      SZ_HALF: if (req_adr[0]) req_err = 1'b1;
      SZ_WORD: if (req_adr[1:0] != 2'b00) req_err = 1'b1;
      SZ_BYTE: ;
    endcase
  end

  // Memory-side drive: granted request translated into the window, idle pattern otherwise.
  always_comb begin
    mem_we_o  = 1'b0;
    mem_adr_o = 32'h0;
    mem_wd_o  = 32'h0;
    mem_sel_o = SZ_WORD;
    if (granted) begin
      mem_we_o  = req_we & ~req_err;
      mem_adr_o = req_adr - BASE_ADR;
      mem_wd_o  = req_wd;
      mem_sel_o = req_sel;
    end
  end

  // Read data is only returned for good reads; writes and errors answer with zero.
  assign resp_rdata = (req_we || req_err) ? 32'h0 : mem_rdata_i;

  // Response registers: one-cycle rvalid pulse to the side granted in the previous cycle.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_rvalid_o <= 1'b0;
      a_rdata_o  <= 32'h0;
      a_err_o    <= 1'b0;
      b_rvalid_o <= 1'b0;
      b_rdata_o  <= 32'h0;
      b_err_o    <= 1'b0;
    end else begin
      a_rvalid_o <= a_gnt_o;
      b_rvalid_o <= b_gnt_o;
      if (a_gnt_o) begin
        a_rdata_o <= resp_rdata;
        a_err_o   <= req_err;
      end
      if (b_gnt_o) begin
        b_rdata_o <= resp_rdata;
        b_err_o   <= req_err;
      end
    end
  end

  // Starvation guard: count consecutive denied B cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk_i) begin
    if (reset_i || !b_req_i || b_gnt_o) begin
      b_wait <= 4'd0;
    end else if (!b_starved) begin
      b_wait <= b_wait + 4'd1;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Conflict counter: wrapping count of cycles where both requesters ask.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      conflict_cnt_o <= 32'h0;
    end else if (a_req_i && b_req_i) begin
      conflict_cnt_o <= conflict_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data-memory access port between requester A (CPU load/store unit) and requester B (debug/program loader).
- Grants at most one access per cycle.
- Translates and checks addresses against the data-memory window.
- Registers the read data and acknowledge.
- Fixed priority to A, with a starvation guard that forces a B grant after a bounded wait.
- Sits between the core/loader and the data-memory access module. Downstream handles byte/half lane shifting per the sel code.

Parameters:
BASE_ADR, 32'h0000_4000, byte address of the first data-memory word
DEPTH, 16384, number of 32-bit words (64 KB)
MAX_WAIT, 4, consecutive denied cycles for B before B is forced ahead of A (1..15)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_i  in  1  synchronous, active-high reset
a_req_i  in  1  A requests an access this cycle
a_we_i  in  1  A write enable (1 = store)
a_adr_i  in  32  A byte address
a_wd_i  in  32  A write data
a_sel_i  in  2  A size: 00 byte, 01 half, 11 word, 10 reserved
a_gnt_o  out  1  A granted this cycle (combinational)
a_rvalid_o  out  1  A response valid, one cycle after grant
a_rdata_o  out  32  A read data (registered)
a_err_o  out  1  A response is an error (qualified by a_rvalid_o)
b_req_i, b_we_i, b_adr_i, b_wd_i, b_sel_i  in  1/1/32/32/2  B request, same meaning as A
b_gnt_o, b_rvalid_o, b_rdata_o, b_err_o  out  1/1/32/1  B response, same meaning as A
mem_we_o  out  1  write enable to data memory
mem_adr_o  out  32  window-relative byte address (adr - BASE_ADR)
mem_wd_o  out  32  write data to memory
mem_sel_o  out  2  size code passed to memory
mem_rdata_i  in  32  asynchronous read data from memory

Behaviour:
- Grant decision is combinational from the request inputs and registered b_wait:
  - only a_req_i: grant A; only b_req_i: grant B; neither: no grant.
  - both: grant B iff b_wait == MAX_WAIT, else grant A.
- b_wait counter, updated each edge:
  - 0 if b_req_i==0 or B granted;
  - +1 if B requests and is denied, saturating at MAX_WAIT.
- At most one of a_gnt_o/b_gnt_o is high in any cycle.
- Memory-side outputs mux from the granted requester. With no grant: mem_we_o=0, mem_adr_o=0, mem_wd_o=0, mem_sel_o=2'b11.
- Error check on the granted request. The request is in error if any of these hold:
  - adr < BASE_ADR, or adr >= BASE_ADR + 4*DEPTH;
  - sel==10;
  - sel==01 and adr[0]==1;
  - sel==11 and adr[1:0]!=0.
- On an error: the request is still granted, but mem_we_o is forced 0.
- Response timing: latency is 1 cycle. On the edge ending a granted cycle, the granted side's rvalid is set to 1 for exactly one cycle.
- Response data and error flag:
  - rdata = mem_rdata_i for a good read; 0 for writes and errors;
  - err = error flag.
- The non-granted side's rvalid is 0. rdata/err hold their last value when rvalid is 0.
- Back-to-back grants every cycle are legal. A requester holding req high gets a new grant and a new response each granted cycle.
- Requester contract: inputs stay stable while req is high and gnt is low.
- Reset (synchronous, overrides all): b_wait=0, all rvalid/err=0, rdata=0. Memory outputs are in the no-grant state while reset_i=1 (grants suppressed).
- A request pending during reset is not granted and produces no response. After reset deasserts, arbitration restarts from b_wait=0.

Optional Feature:
Macro DMEM_ARB_PERF_EN.
- Defined: adds output conflict_cnt_o [31:0].
  - Increments (wrapping) on every cycle where both req are high and reset_i=0.
  - Cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. Reset, then A read adr 32'h4008 sel 11 with mem_rdata_i=32'hDEADBEEF -> a_gnt_o=1 same cycle, mem_adr_o=32'h8, next cycle a_rvalid_o=1, a_rdata_o=32'hDEADBEEF, a_err_o=0.
2. Both req held high, MAX_WAIT=4 -> A granted cycles 1-4, B granted cycle 5, A cycles 6-9, B cycle 10; exactly one gnt per cycle. With PERF_EN: conflict_cnt_o=10 after 10 cycles.
3. B write adr 32'h3FFC (below window) -> b_gnt_o=1, mem_we_o=0, next cycle b_rvalid_o=1, b_err_o=1, b_rdata_o=0.
4. Misaligned cases (A sel 11 adr 32'h4002, A sel 01 adr 32'h4001, sel 10 any addr) -> each error with no memory write. Edge of window: word read at 32'h13FFC ok; read at 32'h14000 -> err.
5. A write adr 32'h4010 sel 00 wd 32'hAB -> mem_we_o=1, mem_wd_o=32'hAB, mem_sel_o=00, next-cycle rvalid=1, rdata=0, err=0.
6. Both req high with b_wait=3, assert reset_i one cycle -> no grant and no rvalid during reset. After release, A granted first and B waits a full MAX_WAIT again.
